// File: rtl/des_output_buffer.sv
// Output buffer behind the DES pipeline: captures every result into a FIFO and meters launch credits.
// Optional DES_OBUF_OVERFLOW_CHECK_EN: sticky overflow flag plus simulation-time protocol checks.
module des_output_buffer #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              pipe_ov,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  level,
  output logic              overflow
);

  localparam int PTR_W = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, reserved;
  logic              issue, pop, push_ok;

  // Credits are withheld while reset is asserted so nothing launches into a pipeline being cleared.
  assign issue_ready = rst && (reserved < DEPTH_C);
  assign issue       = issue_valid & issue_ready;
  assign out_valid   = (count != '0);
  assign pop         = out_valid & out_ready;
  assign push_ok     = pipe_ov & ((count < DEPTH_C) | pop);
  assign out_data    = mem[rd_ptr];
  assign level       = count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      reserved <= '0;
    end else if (issue && !pop) begin
      reserved <= reserved + CNT_W'(1);
    end else if (pop && !issue && reserved != '0) begin
      reserved <= reserved - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= pipe_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so natural rollover is the modulo-DEPTH wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push_ok) begin
        count <= count - CNT_W'(1);
      end
    end
  end

`ifdef DES_OBUF_OVERFLOW_CHECK_EN
  logic drop;
  logic overflow_q;

  assign drop     = pipe_ov & ~push_ok;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert (!drop) else $error("des_output_buffer: result dropped, FIFO full");
      assert (!(pop && reserved == '0)) else $error("des_output_buffer: credit counter underflow");
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_des_output_buffer.sv
// Directed bench for des_output_buffer with a 19-stage pipeline model and reference queue.
module tb_des_output_buffer;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        pipe_ov;
  logic [63:0] pipe_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [5:0]  level;
  logic        overflow;

  logic        inj_ov;
  logic [63:0] inj_data;
  logic [18:0] pv;
  logic [63:0] pd [19];
  logic [31:0] seq;
  logic [63:0] exp_q [$];

  int checks;
  int passes;
  int issued;
  int pops;
  int model_res;
  int first_pop;
  int last_pop;
  int prev_pops;

  des_output_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .pipe_ov     (pipe_ov),
    .pipe_data   (pipe_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .overflow    (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Fixed-latency DES pipeline stand-in; launched words are also queued as the expected order.
  initial seq = '0;
  always @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[17:0], issue_valid & issue_ready};
      pd[0] <= {32'hCAFEF00D, seq};
      for (int i = 1; i < 19; i++) pd[i] <= pd[i-1];
      if (issue_valid && issue_ready) begin
        exp_q.push_back({32'hCAFEF00D, seq});
        seq <= seq + 32'd1;
      end
    end
  end

  assign pipe_ov   = pv[18] | inj_ov;
  assign pipe_data = inj_ov ? inj_data : pd[18];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic iv, input logic ordy, input logic inj, input logic [63:0] idata);
    issue_valid = iv;
    out_ready   = ordy;
    inj_ov      = inj;
    inj_data    = idata;
    #1;
    if (issue_valid && issue_ready) begin
      issued++;
      model_res++;
    end
    if (out_valid && out_ready) begin
      pops++;
      model_res--;
      if (exp_q.size() == 0) checkOutput("pop_unexpected", 64'd1, 64'd0);
      else checkOutput("pop_data", out_data, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic doReset();
    rst         = 1'b0;
    issue_valid = 1'b0;
    out_ready   = 1'b0;
    inj_ov      = 1'b0;
    @(negedge clk);
    checkOutput("rst_issue_ready", issue_ready, 64'd0);
    checkOutput("rst_out_valid", out_valid, 64'd0);
    checkOutput("rst_level", level, 64'd0);
    checkOutput("rst_overflow", overflow, 64'd0);
    exp_q.delete();
    model_res = 0;
    rst = 1'b1;
    #1;
    checkOutput("rel_issue_ready", issue_ready, 64'd1);
    checkOutput("rel_level", level, 64'd0);
  endtask

  initial begin
    checks = 0; passes = 0; issued = 0; pops = 0; model_res = 0;
    rst = 1'b0; issue_valid = 1'b0; out_ready = 1'b0; inj_ov = 1'b0; inj_data = '0;
    $display("[TB] start");
    doReset();

    // Fill: credits stop after exactly DEPTH launches.
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("fill_issued", issued, 64'd32);
    checkOutput("fill_issue_ready", issue_ready, 64'd0);
    for (int i = 0; i < 40 && level != 6'd32; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("fill_level", level, 64'd32);
    checkOutput("fill_overflow", overflow, 64'd0);
    checkOutput("fill_head", out_data, 64'hCAFEF00D_00000000);

    // Drain from full; credit returns one cycle after the first pop.
    pops = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("credit_return", issue_ready, 64'd1);
    for (int i = 0; i < 31; i++) begin
      checkOutput("drain_valid", out_valid, 64'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    checkOutput("drain_pops", pops, 64'd32);
    checkOutput("drain_level", level, 64'd0);
    checkOutput("drain_out_valid", out_valid, 64'd0);

    // Streaming: one launch per cycle, consumer always ready.
    pops = 0; first_pop = -1; last_pop = -1;
    for (int c = 0; c < 125; c++) begin
      prev_pops = pops;
      applyStimulus(c < 100, 1'b1, 1'b0, '0);
      if (pops != prev_pops) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
      end
      checkOutput("stream_level", level <= 6'd1, 64'd1);
    end
    checkOutput("stream_pops", pops, 64'd100);
    checkOutput("stream_no_bubble", last_pop - first_pop, 64'd99);

    // Random launch and 30% consumer duty against the reference queue.
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 3), 1'b0, '0);
      checkOutput("rand_credit", issue_ready, model_res < 32);
      checkOutput("rand_reserved_ge_count", int'(level) <= model_res, 64'd1);
    end
    for (int i = 0; i < 200 && (level != 6'd0 || exp_q.size() != 0); i++)
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("rand_queue_empty", exp_q.size(), 64'd0);
    checkOutput("rand_level", level, 64'd0);
    checkOutput("rand_credits_back", model_res, 64'd0);

    // Unsolicited results beyond capacity: the 33rd is dropped.
    doReset();
    for (int i = 0; i < 33; i++) applyStimulus(1'b0, 1'b0, 1'b1, {32'hBAD0BAD0, 32'(i)});
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("ovf_level", level, 64'd32);
    checkOutput("ovf_head", out_data, 64'hBAD0BAD0_00000000);
`ifdef DES_OBUF_OVERFLOW_CHECK_EN
    checkOutput("ovf_flag", overflow, 64'd1);
`else
    checkOutput("ovf_flag", overflow, 64'd0);
`endif
    doReset();
    checkOutput("ovf_cleared", overflow, 64'd0);

    // Reset mid-operation with 5 stored and 7 in flight.
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 30 && level != 6'd5; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_level", level, 64'd5);
    doReset();
    issued = 0;
    repeat (40) applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("mid_issued", issued, 64'd32);
    for (int i = 0; i < 40 && level != 6'd32; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("mid_refill_level", level, 64'd32);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
